// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: memory address/data, downstream hazard/branch controls and IF/ID outputs.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int CNT_W  = 16
);
  logic              freeze;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_adrs;
  logic [ADDR_W-1:0] inst_adrs;
  logic [INST_W-1:0] inst_data;
  logic [ADDR_W-1:0] if_pc;
  logic [INST_W-1:0] if_inst;
  logic              if_valid;
  logic [CNT_W-1:0]  fetch_count;
  logic              misalign_err;

  modport master (
    input  freeze, branch_taken, branch_adrs, inst_data,
    output inst_adrs, if_pc, if_inst, if_valid, fetch_count, misalign_err
  );

  modport slave (
    output freeze, branch_taken, branch_adrs, inst_data,
    input  inst_adrs, if_pc, if_inst, if_valid, fetch_count, misalign_err
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// IF stage: PC register, zero-latency instruction memory address, IF/ID register
// with freeze and branch redirect/flush, saturating fetch counter, sticky misalign flag.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  bus
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic              valid;
  } ifid_t;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next4;
  ifid_t             ifid;
  logic [CNT_W-1:0]  cnt;
  logic              err;

  // Modulo 2^ADDR_W: the top word wraps to zero silently.
  assign pc_next4 = pc + ADDR_W'(4);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc   <= RESET_PC;
      ifid <= '0;
      cnt  <= '0;
      err  <= 1'b0;
    end else if (bus.branch_taken) begin
      // Redirect beats freeze; IF/ID becomes a NOP bubble.
      pc   <= {bus.branch_adrs[ADDR_W-1:2], 2'b00};
      ifid <= '0;
      if (bus.branch_adrs[1:0] != 2'b00) err <= 1'b1;
    end else if (!bus.freeze) begin
      pc   <= pc_next4;
      ifid <= '{pc: pc_next4, inst: bus.inst_data, valid: 1'b1};
      if (cnt != {CNT_W{1'b1}}) cnt <= cnt + CNT_W'(1);
    end
  end

  assign bus.inst_adrs    = pc;
  assign bus.if_pc        = ifid.pc;
  assign bus.if_inst      = ifid.inst;
  assign bus.if_valid     = ifid.valid;
  assign bus.fetch_count  = cnt;
  assign bus.misalign_err = err;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a reference model pushes the expected
// output state per edge, each scenario task pops and compares after the edge.
module tb_instr_fetch_unit;
  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int CNT_W  = 16;
  localparam logic [31:0] XMASK = 32'hA5A5_0000;

  typedef logic [ADDR_W+ADDR_W+INST_W+1+CNT_W+1-1:0] obs_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  obs_t sb[$];
  obs_t exp_o;

  logic [31:0] m_pc, m_if_pc, m_if_inst;
  logic        m_if_valid, m_err;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(ADDR_W), .INST_W(INST_W), .CNT_W(CNT_W)) bus ();

  instr_fetch_unit #(.ADDR_W(ADDR_W), .INST_W(INST_W), .RESET_PC(32'h0), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  // Combinational instruction memory.
  assign bus.inst_data = bus.inst_adrs ^ XMASK;

  function automatic obs_t observed();
    return {bus.inst_adrs, bus.if_pc, bus.if_inst, bus.if_valid, bus.fetch_count, bus.misalign_err};
  endfunction

  // Drive one cycle of inputs, advance the model, push its expectation, take the edge.
  task automatic drive(input logic r, input logic f, input logic b, input logic [31:0] a);
    rst_n = r; bus.freeze = f; bus.branch_taken = b; bus.branch_adrs = a;
    if (!r) begin
      m_pc = 32'h0; m_if_pc = 0; m_if_inst = 0; m_if_valid = 0; m_cnt = 0; m_err = 0;
    end else if (b) begin
      m_pc = {a[31:2], 2'b00}; m_if_pc = 0; m_if_inst = 0; m_if_valid = 0;
      if (a[1:0] != 2'b00) m_err = 1'b1;
    end else if (!f) begin
      m_if_inst = m_pc ^ XMASK; m_if_pc = m_pc + 32'd4; m_pc = m_pc + 32'd4;
      m_if_valid = 1'b1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    sb.push_back({m_pc, m_if_pc, m_if_inst, m_if_valid, m_cnt, m_err});
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    exp_o = sb.pop_front();
    drive(1'b0, 1'b1, 1'b1, 32'h3);
    exp_o = sb.pop_front();
    checks++;
    if (observed() !== exp_o) begin
      failures++; $display("FAIL reset_state got=%h exp=%h", observed(), exp_o);
    end
    checks++;
    if (bus.inst_adrs !== 32'h0 || bus.if_valid !== 1'b0 || bus.misalign_err !== 1'b0) begin
      failures++; $display("FAIL reset_consts adrs=%h valid=%b err=%b exp 0/0/0", bus.inst_adrs, bus.if_valid, bus.misalign_err);
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      exp_o = sb.pop_front();
      checks++;
      if (observed() !== exp_o) begin
        failures++; $display("FAIL seq cyc%0d got=%h exp=%h", i, observed(), exp_o);
      end
    end
    checks++;
    if (bus.inst_adrs !== 32'd16 || bus.if_pc !== 32'd16 || bus.if_inst !== 32'hA5A5_000C || bus.fetch_count !== 16'd4) begin
      failures++; $display("FAIL seq_end adrs=%0d if_pc=%0d inst=%h cnt=%0d exp 16/16/a5a5000c/4",
                           bus.inst_adrs, bus.if_pc, bus.if_inst, bus.fetch_count);
    end
  endtask

  task automatic test_freeze();
    logic [15:0] cnt0;
    while (m_pc != 32'd52) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      exp_o = sb.pop_front();
      checks++;
      if (observed() !== exp_o) begin
        failures++; $display("FAIL frz_run got=%h exp=%h", observed(), exp_o);
      end
    end
    cnt0 = m_cnt;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      exp_o = sb.pop_front();
      checks++;
      if (observed() !== exp_o || bus.inst_adrs !== 32'd52 || bus.if_pc !== 32'd52 || bus.fetch_count !== cnt0) begin
        failures++; $display("FAIL frz_hold cyc%0d got=%h exp=%h", i, observed(), exp_o);
      end
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    exp_o = sb.pop_front();
    checks++;
    if (observed() !== exp_o || bus.if_pc !== 32'd56 || bus.if_inst !== (32'd52 ^ XMASK)) begin
      failures++; $display("FAIL frz_release got=%h exp=%h", observed(), exp_o);
    end
  endtask

  task automatic test_branch();
    while (m_pc != 32'd196) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      exp_o = sb.pop_front();
      checks++;
      if (observed() !== exp_o) begin
        failures++; $display("FAIL br_run got=%h exp=%h", observed(), exp_o);
      end
    end
    drive(1'b1, 1'b0, 1'b1, 32'd136);
    exp_o = sb.pop_front();
    checks++;
    if (observed() !== exp_o || bus.inst_adrs !== 32'd136 || bus.if_valid !== 1'b0 || bus.if_inst !== 32'h0) begin
      failures++; $display("FAIL br_bubble got=%h exp=%h", observed(), exp_o);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    exp_o = sb.pop_front();
    checks++;
    if (observed() !== exp_o || bus.if_pc !== 32'd140 || bus.if_valid !== 1'b1) begin
      failures++; $display("FAIL br_target got=%h exp=%h", observed(), exp_o);
    end
  endtask

  task automatic test_branch_freeze_misalign();
    drive(1'b1, 1'b1, 1'b1, 32'h102);
    exp_o = sb.pop_front();
    checks++;
    if (observed() !== exp_o || bus.inst_adrs !== 32'h100 || bus.if_valid !== 1'b0 || bus.misalign_err !== 1'b1) begin
      failures++; $display("FAIL br_frz_mis got=%h exp=%h", observed(), exp_o);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, i[0], 1'b0, 32'h0);
      exp_o = sb.pop_front();
      checks++;
      if (observed() !== exp_o || bus.misalign_err !== 1'b1) begin
        failures++; $display("FAIL mis_sticky cyc%0d got=%h exp=%h", i, observed(), exp_o);
      end
    end
  endtask

  task automatic test_wrap_saturate();
    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    exp_o = sb.pop_front();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    exp_o = sb.pop_front();
    checks++;
    if (observed() !== exp_o || bus.inst_adrs !== 32'h0 || bus.if_pc !== 32'h0 || bus.if_inst !== 32'h5A5A_FFFC) begin
      failures++; $display("FAIL pc_wrap got=%h exp=%h", observed(), exp_o);
    end
    for (int i = 0; i < 65540; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      exp_o = sb.pop_front();
      checks++;
      if (observed() !== exp_o) begin
        failures++; $display("FAIL sat_run cyc%0d got=%h exp=%h", i, observed(), exp_o);
      end
    end
    checks++;
    if (bus.fetch_count !== 16'hFFFF) begin
      failures++; $display("FAIL cnt_saturate got=%h exp=ffff", bus.fetch_count);
    end
  endtask

  task automatic test_reset_in_freeze();
    drive(1'b1, 1'b0, 1'b1, 32'd80);
    exp_o = sb.pop_front();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      exp_o = sb.pop_front();
      checks++;
      if (observed() !== exp_o || bus.inst_adrs !== 32'd80) begin
        failures++; $display("FAIL rst_frz_pre got=%h exp=%h", observed(), exp_o);
      end
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    exp_o = sb.pop_front();
    checks++;
    if (observed() !== exp_o || bus.inst_adrs !== 32'h0 || bus.fetch_count !== 16'h0 || bus.misalign_err !== 1'b0) begin
      failures++; $display("FAIL rst_in_freeze got=%h exp=%h", observed(), exp_o);
    end
  endtask

  initial begin
    rst_n = 1'b0; bus.freeze = 1'b0; bus.branch_taken = 1'b0; bus.branch_adrs = '0;
    #2;
    test_reset();
    test_sequential();
    test_freeze();
    test_branch();
    test_branch_freeze_misalign();
    test_wrap_saturate();
    test_reset_in_freeze();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction-fetch stage of the five-stage pipeline. Holds the program counter, drives the byte address into the combinational instruction memory, captures the returned word into the IF/ID pipeline register, and honours hazard freeze and branch redirect/flush from downstream stages. Sits between the instruction memory (read-only, byte-addressed, word-aligned, zero-latency) and the ID stage.

## Interface

Parameters:
- `ADDR_W`, 32, PC / instruction-address width
- `INST_W`, 32, instruction word width
- `RESET_PC`, 0, PC value after reset; must be a multiple of 4
- `CNT_W`, 16, width of the fetched-instruction counter

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous active-low reset
- `freeze`  in  1  hazard-unit stall; hold PC and IF/ID
- `branch_taken`  in  1  branch/jump resolved taken this cycle
- `branch_adrs`  in  ADDR_W  branch target byte address
- `inst_adrs`  out  ADDR_W  byte address to instruction memory (= PC)
- `inst_data`  in  INST_W  instruction word returned for `inst_adrs`, same cycle
- `if_pc`  out  ADDR_W  IF/ID: PC+4 of the captured instruction
- `if_inst`  out  INST_W  IF/ID: captured instruction
- `if_valid`  out  1  IF/ID holds a real fetched instruction
- `fetch_count`  out  CNT_W  instructions delivered to IF/ID, saturating
- `misalign_err`  out  1  sticky: a taken branch target had bits [1:0] ≠ 0

## Operation

- PC register `pc`; `inst_adrs` = `pc` combinationally (no added latency).
- Per rising edge, priority highest first:
  - `rst_n`=0: `pc`←RESET_PC; `if_pc`←0; `if_inst`←0; `if_valid`←0; `fetch_count`←0; `misalign_err`←0. Overrides freeze/branch.
  - `branch_taken`=1: `pc`←{`branch_adrs`[ADDR_W-1:2],2'b00}; IF/ID flushed: `if_inst`←0 (NOP encoding), `if_valid`←0, `if_pc`←0; `fetch_count` unchanged; if `branch_adrs`[1:0]≠0, `misalign_err`←1. Branch wins over simultaneous `freeze`.
  - `freeze`=1: `pc`, `if_pc`, `if_inst`, `if_valid`, `fetch_count` all hold.
  - else: `pc`←`pc`+4; `if_pc`←`pc`+4; `if_inst`←`inst_data`; `if_valid`←1; `fetch_count`←`fetch_count`+1 unless all-ones (saturate).
- Arithmetic: `pc`+4 is modulo 2^ADDR_W; 0xFFFF_FFFC wraps to 0x0000_0000, no flag.
- `misalign_err` only cleared by reset.
- No internal FSM beyond the PC/IF-ID registers; freeze and branch are level inputs sampled each edge.

## Timing

- Reset outputs: `inst_adrs`=RESET_PC, `if_pc`=0, `if_inst`=0, `if_valid`=0, `fetch_count`=0, `misalign_err`=0.
- First real instruction (word at RESET_PC) appears on `if_inst` one edge after reset deasserts, `if_valid`=1 same cycle.
- Throughput one instruction per cycle when not frozen.
- Branch: target address on `inst_adrs` the cycle after `branch_taken`; IF/ID shows a bubble that cycle; target instruction in IF/ID one edge later (one-cycle IF penalty; downstream flushes handled elsewhere).
- Freeze of N cycles holds `inst_adrs` and IF/ID for exactly N cycles; fetch resumes on the first edge with `freeze`=0.
- Reset asserted mid-stream (including during freeze or with `branch_taken`=1) takes effect on that edge; no partial update.

## Test plan

- Reset then 4 free-running cycles with memory model `inst_data`=`inst_adrs`^0xA5A5_0000 → `inst_adrs` 0,4,8,12,16; `if_pc` 4,8,12,16; `if_inst` 0xA5A5_0000,…_0004,…_0008,…_000C; `fetch_count`=4.
- At `pc`=52 assert `freeze` 3 cycles → `inst_adrs` stays 52, IF/ID (`if_pc`=52) unchanged, `fetch_count` constant; after release `if_inst` = word at 52, `if_pc`=56.
- At `pc`=196 assert `branch_taken`, `branch_adrs`=136 → next `inst_adrs`=136, `if_valid`=0, `if_inst`=0; following edge `if_pc`=140, `if_valid`=1.
- `branch_taken` and `freeze` together, `branch_adrs`=0x102 → `pc`=0x100, IF/ID flushed, `misalign_err`=1 and stays 1 until reset.
- Force `pc` to 0xFFFF_FFFC via branch, run 1 cycle → `inst_adrs`=0, `if_pc`=0; preload count near max, run → `fetch_count` saturates at 0xFFFF.
- Assert `rst_n`=0 during an active freeze with `pc`=80 → next edge all outputs at reset values, `inst_adrs`=RESET_PC.
